// File: rtl/mc_control.sv
// Multicycle control FSM for the MIPS core: sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared datapath.
// Optional feature: define BNE_EN to decode opcode 05 (bne) as an inverted-sense branch.
module mc_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic [1:0] pcsrc,
   output logic       illegal,
   output logic       bus_error,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_wait;

   logic       w_mem_state;
   logic       w_stall;
   logic       w_timeout;
   logic       w_taken;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_iord;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regdst;
   logic       w_memtoreg;
   logic       w_regwrite;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [2:0] w_alucontrol;
   logic [1:0] w_pcsrc;
   logic       w_illegal;

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_stall     = w_mem_state && !mem_ready;
   assign w_timeout   = w_stall && (r_wait == CNT_W'(TIMEOUT - 1));

`ifdef BNE_EN
   // Branch sense is captured while the opcode is known to be valid in DECODE.
   logic r_bne;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bne <= 1'b0;
      end else if (r_state == S_DECODE) begin
         r_bne <= (opcode == 6'h05);
      end
   end

   assign w_taken = r_bne ? !zero : zero;
`else
   assign w_taken = zero;
`endif

   // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned (no latch).
   always_comb begin
      w_next       = r_state;
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      w_iord       = 1'b0;
      w_memwrite   = 1'b0;
      w_irwrite    = 1'b0;
      w_regdst     = 1'b0;
      w_memtoreg   = 1'b0;
      w_regwrite   = 1'b0;
      w_alusrca    = 1'b0;
      w_alusrcb    = 2'b00;
      w_alucontrol = 3'b000;
      w_pcsrc      = 2'b00;
      w_illegal    = 1'b0;

      unique case (r_state)
         S_FETCH: begin
            w_alusrcb    = 2'b01;
            w_alucontrol = ALU_ADD;
            w_irwrite    = mem_ready;
            w_pcwrite    = mem_ready;
            if (mem_ready) w_next = S_DECODE;
            else if (w_timeout) w_next = S_FETCH;
         end
         S_DECODE: begin
            w_alusrcb    = 2'b11;
            w_alucontrol = ALU_ADD;
            case (opcode)
               6'h23, 6'h2B: w_next = S_MEMADR;
               6'h00:        w_next = S_RTEXEC;
               6'h04:        w_next = S_BRANCH;
`ifdef BNE_EN
               6'h05:        w_next = S_BRANCH;
`endif
               6'h08:        w_next = S_ADDIEX;
               6'h02:        w_next = S_JUMP;
               default: begin
                  w_illegal = 1'b1;
                  w_next    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            w_alusrca    = 1'b1;
            w_alusrcb    = 2'b10;
            w_alucontrol = ALU_ADD;
            w_next       = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_iord = 1'b1;
            if (mem_ready || w_timeout) w_next = mem_ready ? S_MEMWB : S_FETCH;
         end
         S_MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            // The strobe stays up through a timeout cycle; only the FSM gives up.
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
            if (mem_ready || w_timeout) w_next = S_FETCH;
         end
         S_RTEXEC: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b00;
            w_next    = S_ALUWB;
            case (funct)
               6'h20:   w_alucontrol = ALU_ADD;
               6'h22:   w_alucontrol = ALU_SUB;
               6'h24:   w_alucontrol = ALU_AND;
               6'h25:   w_alucontrol = ALU_OR;
               6'h2A:   w_alucontrol = ALU_SLT;
               default: begin
                  w_illegal = 1'b1;
                  w_next    = S_FETCH;
               end
            endcase
         end
         S_ALUWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            w_alusrca    = 1'b1;
            w_alusrcb    = 2'b00;
            w_alucontrol = ALU_SUB;
            w_pcsrc      = 2'b01;
            w_branch     = 1'b1;
            w_next       = S_FETCH;
         end
         S_ADDIEX: begin
            w_alusrca    = 1'b1;
            w_alusrcb    = 2'b10;
            w_alucontrol = ALU_ADD;
            w_next       = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_JUMP: begin
            w_pcsrc   = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         // Cleared on any state change, on completion, and on timeout re-entry to FETCH.
         if ((w_next != r_state) || w_timeout || !w_stall) r_wait <= '0;
         else                                              r_wait <= r_wait + 1'b1;
      end
   end

   // Reset forces every output quiet, so nothing is written in the cycle reset is sampled.
   assign pc_en      = !reset && (w_pcwrite || (w_branch && w_taken));
   assign iord       = !reset && w_iord;
   assign memwrite   = !reset && w_memwrite;
   assign irwrite    = !reset && w_irwrite;
   assign regdst     = !reset && w_regdst;
   assign memtoreg   = !reset && w_memtoreg;
   assign regwrite   = !reset && w_regwrite;
   assign alusrca    = !reset && w_alusrca;
   assign alusrcb    = reset ? 2'b00 : w_alusrcb;
   assign alucontrol = reset ? 3'b000 : w_alucontrol;
   assign pcsrc      = reset ? 2'b00 : w_pcsrc;
   assign illegal    = !reset && w_illegal;
   assign bus_error  = !reset && w_timeout;
   assign state      = reset ? S_FETCH : r_state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: instruction-level reference model with random stalls, timeouts and resets.
// Build with BNE_EN defined to exercise the bne option consistently with the RTL.
module tb_mc_control;

   localparam int TIMEOUT = 16;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_RTEXEC = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluc;
      logic [1:0] pcsrc;
      logic       illegal;
      logic       bus_error;
      logic [3:0] st;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic [1:0] pcsrc;
   logic       illegal, bus_error;
   logic [3:0] state;

   ctl_t got;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   allow_abort = 1'b0;

   always #5 clk = ~clk;

   mc_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .pcsrc      (pcsrc),
      .illegal    (illegal),
      .bus_error  (bus_error),
      .state      (state)
   );

   assign got = {pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, alucontrol, pcsrc, illegal, bus_error, state};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   // One reset cycle: every output (including the debug state, FETCH) must be zero.
   task automatic rst_cyc(input string tag);
      @(negedge clk);
      reset     = 1'b1;
      opcode    = 6'($urandom);
      funct     = 6'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
      #1;
      check(tag, 32'(got), 32'd0);
   endtask

   task automatic cyc(input string tag, input ctl_t exp, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, output bit aborted);
      aborted = 1'b0;
      if (allow_abort && ($urandom_range(0, 63) == 0)) begin
         rst_cyc({tag, "/reset"});
         aborted = 1'b1;
      end else begin
         @(negedge clk);
         reset     = 1'b0;
         opcode    = op;
         funct     = fn;
         zero      = z;
         mem_ready = mr;
         #1;
         check(tag, 32'(got), 32'(exp));
      end
   endtask

   // Memory-wait phase. mode: 0 ready at once, 1 random, 2 never, 3 ready on the timeout cycle, 4 ready after 3 stalls.
   task automatic mem_phase(input string tag, input ctl_t base, input bit is_fetch, input int mode,
                            input logic [5:0] op, input logic [5:0] fn, input logic z,
                            output bit ok, output bit aborted);
      ok      = 1'b0;
      aborted = 1'b0;
      for (int w = 0; w < TIMEOUT; w++) begin
         logic mr;
         ctl_t e;
         case (mode)
            0:       mr = 1'b1;
            1:       mr = 1'($urandom);
            2:       mr = 1'b0;
            3:       mr = (w == TIMEOUT - 1);
            default: mr = (w == 3);
         endcase
         e = base;
         if (mr) begin
            if (is_fetch) begin
               e.irwrite = 1'b1;
               e.pc_en   = 1'b1;
            end
         end else if (w == TIMEOUT - 1) begin
            e.bus_error = 1'b1;
         end
         cyc(tag, e, op, fn, z, mr, aborted);
         if (aborted) return;
         if (mr) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Runs one instruction from FETCH back to FETCH, predicting every cycle from the instruction's class.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fmode, input int dmode);
      ctl_t e;
      bit   ok, ab;
      int   cls;
      e = '0; e.st = S_FETCH; e.alusrcb = 2'b01; e.aluc = 3'b010;
      mem_phase("fetch", e, 1'b1, fmode, 6'($urandom), 6'($urandom), z, ok, ab);
      if (!ok) return;

      case (op)
         6'h23, 6'h2B: cls = 1;
         6'h00:        cls = 2;
         6'h04:        cls = 3;
`ifdef BNE_EN
         6'h05:        cls = 3;
`endif
         6'h08:        cls = 4;
         6'h02:        cls = 5;
         default:      cls = 0;
      endcase
      e = '0; e.st = S_DECODE; e.alusrcb = 2'b11; e.aluc = 3'b010; e.illegal = (cls == 0);
      cyc("decode", e, op, fn, z, 1'($urandom), ab);
      if (ab || cls == 0) return;

      case (cls)
         1: begin
            e = '0; e.st = S_MEMADR; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
            cyc("memadr", e, op, fn, z, 1'($urandom), ab);
            if (ab) return;
            if (op == 6'h23) begin
               e = '0; e.st = S_MEMRD; e.iord = 1'b1;
               mem_phase("memrd", e, 1'b0, dmode, op, fn, z, ok, ab);
               if (!ok) return;
               e = '0; e.st = S_MEMWB; e.memtoreg = 1'b1; e.regwrite = 1'b1;
               cyc("memwb", e, op, fn, z, 1'($urandom), ab);
            end else begin
               e = '0; e.st = S_MEMWR; e.iord = 1'b1; e.memwrite = 1'b1;
               mem_phase("memwr", e, 1'b0, dmode, op, fn, z, ok, ab);
            end
         end
         2: begin
            e = '0; e.st = S_RTEXEC; e.alusrca = 1'b1;
            case (fn)
               6'h20:   e.aluc = 3'b010;
               6'h22:   e.aluc = 3'b110;
               6'h24:   e.aluc = 3'b000;
               6'h25:   e.aluc = 3'b001;
               6'h2A:   e.aluc = 3'b111;
               default: e.illegal = 1'b1;
            endcase
            cyc("rtexec", e, op, fn, z, 1'($urandom), ab);
            if (ab || e.illegal) return;
            e = '0; e.st = S_ALUWB; e.regdst = 1'b1; e.regwrite = 1'b1;
            cyc("aluwb", e, op, fn, z, 1'($urandom), ab);
         end
         3: begin
            e = '0; e.st = S_BRANCH; e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
            e.pc_en = (op == 6'h04) ? z : !z;
            cyc("branch", e, op, fn, z, 1'($urandom), ab);
         end
         4: begin
            e = '0; e.st = S_ADDIEX; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
            cyc("addiex", e, op, fn, z, 1'($urandom), ab);
            if (ab) return;
            e = '0; e.st = S_ADDIWB; e.regwrite = 1'b1;
            cyc("addiwb", e, op, fn, z, 1'($urandom), ab);
         end
         default: begin
            e = '0; e.st = S_JUMP; e.pcsrc = 2'b10; e.pc_en = 1'b1;
            cyc("jump", e, op, fn, z, 1'($urandom), ab);
         end
      endcase
   endtask

   function automatic int pick_mode();
      int r;
      r = $urandom_range(0, 15);
      if (r < 9)  return 0;
      if (r < 13) return 1;
      if (r == 13) return 2;
      if (r == 14) return 3;
      return 4;
   endfunction

   function automatic logic [5:0] pick_op();
      logic [5:0] ops [8];
      ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F};
      if ($urandom_range(0, 9) == 0) return 6'($urandom);
      return ops[$urandom_range(0, 7)];
   endfunction

   function automatic logic [5:0] pick_fn();
      logic [5:0] fns [5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      if ($urandom_range(0, 7) == 0) return 6'($urandom);
      return fns[$urandom_range(0, 4)];
   endfunction

   initial begin
      reset     = 1'b1;
      opcode    = 6'h23;
      funct     = 6'h00;
      zero      = 1'b0;
      mem_ready = 1'b0;

      repeat (3) rst_cyc("reset");

      run_instr(6'h23, 6'h00, 1'b0, 0, 0);   // lw, no stalls
      run_instr(6'h2B, 6'h00, 1'b0, 0, 0);   // sw, no stalls
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
      run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
      run_instr(6'h02, 6'h00, 1'b0, 4, 0);   // j after 3 fetch stalls
      run_instr(6'h23, 6'h00, 1'b0, 0, 2);   // lw with MEMRD timeout
      run_instr(6'h2B, 6'h00, 1'b0, 0, 2);   // sw with MEMWR timeout
      run_instr(6'h2B, 6'h00, 1'b0, 0, 3);   // sw ready on the timeout cycle
      run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw ready on the timeout cycle
      run_instr(6'h00, 6'h00, 1'b0, 2, 0);   // fetch timeout
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
      run_instr(6'h00, 6'h22, 1'b0, 0, 0);   // R-type sub
      run_instr(6'h00, 6'h3F, 1'b0, 0, 0);   // illegal funct
      run_instr(6'h08, 6'h00, 1'b1, 0, 0);   // addi
      run_instr(6'h05, 6'h00, 1'b0, 0, 0);   // bne (or illegal without the option)
      run_instr(6'h05, 6'h00, 1'b1, 0, 0);

      allow_abort = 1'b1;
      repeat (400) run_instr(pick_op(), pick_fn(), 1'($urandom), pick_mode(), pick_mode());
      allow_abort = 1'b0;
      run_instr(6'h23, 6'h00, 1'b0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
